elastic_fifo: RTL and testbench

Circular-buffer FIFO of `NUM_SLOTS` entries on a single handshake channel, placed directly downstream of an `oehb` chain. The chain cuts the valid/data path; this block absorbs back-pressure and cuts the ready path. `ins_ready` is derived only from registered state, never from `outs_ready`. Together the two blocks give a fully registered buffer.

---
 rtl/elastic_fifo_pkg.sv | 14 +
 rtl/elastic_fifo.sv | 91 +++++++++
 tb/tb_elastic_fifo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/elastic_fifo_pkg.sv
// Shared helpers for handshake components: pointer-width computation.
package elastic_fifo_pkg;

    // Ceiling log2. Returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/elastic_fifo.sv
// elastic_fifo: circular-buffer FIFO that absorbs back-pressure and cuts the
// ready path. ins_ready and outs_valid come straight from registered flags,
// so neither depends combinationally on the opposite side of the channel.
module elastic_fifo
    import elastic_fifo_pkg::*;
#(
    parameter int DATA_TYPE = 32,
    parameter int NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int PTR_W = (clog2(NUM_SLOTS) > 1) ? clog2(NUM_SLOTS) : 1;

    logic [DATA_TYPE-1:0] mem_q [0:NUM_SLOTS-1];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 push, pop;
    logic [PTR_W-1:0]     headNext, tailNext;

    // Advance a pointer by one, wrapping at the last slot (depth need not be
    // a power of two, so the wrap is explicit).
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_SLOTS - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign ins_ready  = !full_q;
    assign outs_valid = !empty_q;
    assign outs       = mem_q[head_q];

    assign push     = ins_valid & !full_q;
    assign pop      = !empty_q & outs_ready;
    assign headNext = nextPtr(head_q);
    assign tailNext = nextPtr(tail_q);

    // Next-state for pointers and flags; simultaneous push/pop keeps flags.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        full_d  = full_q;
        empty_d = empty_q;
        if (push) begin
            tail_d = tailNext;
        end
        if (pop) begin
            head_d = headNext;
        end
        if (push && !pop) begin
            empty_d = 1'b0;
            full_d  = (tailNext == head_q);
        end else if (pop && !push) begin
            full_d  = 1'b0;
            empty_d = (headNext == tail_q);
        end
    end

    // Control state with synchronous reset; stored tokens are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage write on push; left untouched by reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[tail_q] <= ins;
        end
    end

endmodule

// File: tb/tb_elastic_fifo.sv
// Testbench for elastic_fifo: a depth-4 and a depth-3 instance share clock and
// reset; an occupancy model plus a scoreboard queue predict every output.
module tb_elastic_fifo;

    logic        clk;
    logic        rst;

    logic [31:0] ins4, outs4;
    logic        insValid4, insReady4, outsValid4, outsReady4;
    logic [31:0] ins3, outs3;
    logic        insValid3, insReady3, outsValid3, outsReady3;

    int          checks;
    int          failures;
    logic [31:0] sb[$];
    logic        stallPrev;
    logic [31:0] prevOuts;
    logic [31:0] dataCnt;

    elastic_fifo #(.DATA_TYPE(32), .NUM_SLOTS(4)) dut4 (
        .clk(clk), .rst(rst),
        .ins(ins4), .ins_valid(insValid4), .ins_ready(insReady4),
        .outs(outs4), .outs_valid(outsValid4), .outs_ready(outsReady4)
    );

    elastic_fifo #(.DATA_TYPE(32), .NUM_SLOTS(3)) dut3 (
        .clk(clk), .rst(rst),
        .ins(ins3), .ins_valid(insValid3), .ins_ready(insReady3),
        .outs(outs3), .outs_valid(outsValid3), .outs_ready(outsReady3)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Hold reset for n edges; the model forgets every stored token.
    task automatic applyReset(input int n);
        rst = 1'b1;
        insValid4 = 1'b0; outsReady4 = 1'b0; ins4 = '0;
        insValid3 = 1'b0; outsReady3 = 1'b0; ins3 = '0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        stallPrev = 1'b0;
    endtask

    // One cycle on the selected instance (0: depth 4, 1: depth 3). Outputs are
    // sampled at the falling edge and compared with the model before the
    // rising edge commits the handshakes.
    task automatic applyStimulus(input int sel, input logic v,
                                 input logic [31:0] d, input logic r);
        int          depth;
        logic        obsReady, obsValid, expReady, expValid;
        logic [31:0] obsOuts;
        depth = (sel != 0) ? 3 : 4;
        if (sel == 0) begin
            insValid4 = v; ins4 = d; outsReady4 = r;
        end else begin
            insValid3 = v; ins3 = d; outsReady3 = r;
        end
        @(negedge clk);
        obsReady = (sel == 0) ? insReady4  : insReady3;
        obsValid = (sel == 0) ? outsValid4 : outsValid3;
        obsOuts  = (sel == 0) ? outs4      : outs3;
        expReady = (sb.size() < depth);
        expValid = (sb.size() > 0);
        checkOutput("ins_ready", 32'(obsReady), 32'(expReady));
        checkOutput("outs_valid", 32'(obsValid), 32'(expValid));
        if (expValid) begin
            checkOutput("outs", obsOuts, sb[0]);
            if (stallPrev) begin
                checkOutput("outs_stable", obsOuts, prevOuts);
            end
        end
        if (expValid && r) begin
            void'(sb.pop_front());
        end
        if (v && expReady) begin
            sb.push_back(d);
        end
        stallPrev = expValid && !r;
        prevOuts  = obsOuts;
        @(posedge clk);
        #1;
        if (sel == 0) begin
            insValid4 = 1'b0; outsReady4 = 1'b0;
        end else begin
            insValid3 = 1'b0; outsReady3 = 1'b0;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        stallPrev = 1'b0;
        prevOuts  = '0;
        dataCnt   = '0;

        // Reset state on both instances
        applyReset(2);
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0);

        // Fill to full with the consumer stalled, then offer a fifth token
        applyStimulus(0, 1'b1, 32'h11, 1'b0);
        applyStimulus(0, 1'b1, 32'h22, 1'b0);
        applyStimulus(0, 1'b1, 32'h33, 1'b0);
        applyStimulus(0, 1'b1, 32'h44, 1'b0);
        applyStimulus(0, 1'b1, 32'h55, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 32'h0, 1'b1);

        // Streaming at one token per cycle
        for (int i = 0; i < 100; i++) applyStimulus(0, 1'b1, 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 32'h0, 1'b1);

        // Full, then a single pop: ready rises only on the following cycle
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 32'(32'h60 + i), 1'b0);
        applyStimulus(0, 1'b1, 32'h66, 1'b1);
        applyStimulus(0, 1'b1, 32'h77, 1'b0);
        applyStimulus(0, 1'b1, 32'h88, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1'b0, 32'h0, 1'b1);

        // Reset with two tokens stored, then a fresh push
        applyStimulus(0, 1'b1, 32'hC1, 1'b0);
        applyStimulus(0, 1'b1, 32'hC2, 1'b0);
        applyReset(1);
        applyStimulus(0, 1'b1, 32'hAB, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        applyStimulus(0, 1'b0, 32'h0, 1'b1);

        // Depth-3 wrap-around with random valid/ready
        for (int i = 0; i < 40; i++) begin
            logic v, r;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (v && sb.size() < 3) begin
                applyStimulus(1, v, dataCnt, r);
                dataCnt = dataCnt + 1;
            end else begin
                applyStimulus(1, v, dataCnt, r);
            end
        end
        for (int i = 0; i < 5; i++) applyStimulus(1, 1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
